// File: rtl/bcd_check_seq_pkg.sv
// Shared constants and FSM state type for the BCD frame checker.
package bcd_check_seq_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned BCD_MAX    = 9;
    localparam int unsigned NUM_W      = NUM_DIGITS * DIGIT_W;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        RESULT  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_check_seq_digit_shreg.sv
// Digit shift register for bcd_check_seq: assembles a frame LSD-first, counts
// accepted digits and remembers whether any of them exceeded BCD_MAX.
module bcd_digit_shreg #(
    parameter int unsigned NUM_DIGITS = bcd_check_seq_pkg::NUM_DIGITS,
    parameter int unsigned DIGIT_W    = bcd_check_seq_pkg::DIGIT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          load,
    input  logic                          bad_clr,
    input  logic [DIGIT_W-1:0]            digit_in,
    output logic [NUM_DIGITS*DIGIT_W-1:0] num_out,
    output logic                          bad,
    output logic                          last
);

    import bcd_check_seq_pkg::*;

    localparam int unsigned NW    = NUM_DIGITS * DIGIT_W;
    localparam int unsigned CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic             digit_bad;

    assign digit_bad = (32'(digit_in) > BCD_MAX);
    assign last      = load && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_out <= '0;
            cnt     <= '0;
            bad     <= 1'b0;
        end else if (clr) begin
            num_out <= '0;
            cnt     <= '0;
            bad     <= 1'b0;
        end else begin
            if (load) begin
                // New digit enters at the top so the first digit ends in [DIGIT_W-1:0].
                num_out <= {digit_in, num_out[NW-1:DIGIT_W]};
                cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
            if (bad_clr)
                bad <= 1'b0;
            else if (load && digit_bad)
                bad <= 1'b1;
        end
    end

endmodule

// File: rtl/bcd_check_seq.sv
// BCD frame collector/checker: gathers NUM_DIGITS digits, lets an external
// checker judge the word, and holds the verdict until consumed.
// Optional pass counter enabled by macro BCD_CHECK_SEQ_PASSCNT_EN.
module bcd_check_seq #(
    parameter int unsigned NUM_DIGITS = bcd_check_seq_pkg::NUM_DIGITS,
    parameter int unsigned DIGIT_W    = bcd_check_seq_pkg::DIGIT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic [DIGIT_W-1:0]            digit_in,
    input  logic                          digit_valid,
    output logic                          digit_ready,
    output logic [NUM_DIGITS*DIGIT_W-1:0] num_out,
    input  logic                          chk_result,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic                          res_bit,
    output logic                          err
`ifdef BCD_CHECK_SEQ_PASSCNT_EN
    ,
    output logic [7:0]                    pass_cnt
`endif
);

    import bcd_check_seq_pkg::*;

    state_t state;
    state_t state_nxt;
    logic   load;
    logic   handshake;
    logic   bad;
    logic   last;

    bcd_digit_shreg #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (DIGIT_W)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clear),
        .load     (load),
        .bad_clr  (handshake),
        .digit_in (digit_in),
        .num_out  (num_out),
        .bad      (bad),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = COLLECT;
        end else begin
            case (state)
                COLLECT: if (last)      state_nxt = CHECK;
                CHECK:                  state_nxt = RESULT;
                RESULT:  if (res_ready) state_nxt = COLLECT;
                default:                state_nxt = COLLECT;
            endcase
        end
    end

    // clear masks both the digit accept and the verdict handshake.
    always_comb begin
        digit_ready = (state == COLLECT);
        load        = digit_valid && digit_ready && !clear;
        handshake   = (state == RESULT) && res_ready && !clear;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_bit   <= 1'b0;
            err       <= 1'b0;
        end else if (clear) begin
            res_valid <= 1'b0;
        end else if (state == CHECK) begin
            res_bit   <= chk_result && !bad;
            err       <= bad;
            res_valid <= 1'b1;
        end else if (handshake) begin
            res_valid <= 1'b0;
        end
    end

`ifdef BCD_CHECK_SEQ_PASSCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pass_cnt <= '0;
        else if (handshake && res_bit && (pass_cnt != 8'hFF))
            pass_cnt <= pass_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_bcd_check_seq.sv
// Directed self-checking bench for bcd_check_seq (default 4 x 4-bit digits).
module tb_bcd_check_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        digit_ready;
    logic [15:0] num_out;
    logic        chk_result;
    logic        res_valid;
    logic        res_ready;
    logic        res_bit;
    logic        err;
`ifdef BCD_CHECK_SEQ_PASSCNT_EN
    logic [7:0]  pass_cnt;
`endif

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    bcd_check_seq #(
        .NUM_DIGITS (4),
        .DIGIT_W    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .num_out     (num_out),
        .chk_result  (chk_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_bit     (res_bit),
        .err         (err)
`ifdef BCD_CHECK_SEQ_PASSCNT_EN
        ,
        .pass_cnt    (pass_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic send_digit(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        @(posedge clk); #1;
        digit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] digs);
        for (int i = 0; i < 4; i++) send_digit(digs[i*4 +: 4]);
    endtask

    task automatic handshake_cycle();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; digit_in = '0; digit_valid = 1'b0;
        chk_result = 1'b0; res_ready = 1'b0;
        #12;
        nvec++;
        if ({res_valid, res_bit, err} !== 3'b000 || num_out !== 16'h0000) begin
            nerr++;
            $display("FAIL reset_outputs: got rv/rb/err=%b%b%b num=%h, want 000 0000",
                     res_valid, res_bit, err, num_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        nvec++;
        if (digit_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_ready: got %b want 1", digit_ready);
        end
    endtask

    task automatic test_frames();
        logic [15:0] digs [3];
        logic        chk  [3];
        logic [15:0] enum_ [3];
        logic        ebit [3];
        logic        eerr [3];
        // digs listed so that [3:0] is the first digit sent
        digs[0] = 16'h4353; chk[0] = 1'b1; enum_[0] = 16'h4353; ebit[0] = 1'b1; eerr[0] = 1'b0;
        digs[1] = 16'h3578; chk[1] = 1'b0; enum_[1] = 16'h3578; ebit[1] = 1'b0; eerr[1] = 1'b0;
        digs[2] = 16'h9C99; chk[2] = 1'b1; enum_[2] = 16'h9C99; ebit[2] = 1'b0; eerr[2] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            chk_result = chk[f];
            send_frame(digs[f]);
            nvec++;
            if (res_valid !== 1'b0 || digit_ready !== 1'b0 || num_out !== enum_[f]) begin
                nerr++;
                $display("FAIL frame%0d_check: rv=%b rdy=%b num=%h, want rv=0 rdy=0 num=%h",
                         f, res_valid, digit_ready, num_out, enum_[f]);
            end
            @(posedge clk); #1;
            nvec++;
            if (res_valid !== 1'b1 || res_bit !== ebit[f] || err !== eerr[f] || num_out !== enum_[f]) begin
                nerr++;
                $display("FAIL frame%0d_result: rv=%b bit=%b err=%b num=%h, want 1 %b %b %h",
                         f, res_valid, res_bit, err, num_out, ebit[f], eerr[f], enum_[f]);
            end
            handshake_cycle();
            nvec++;
            if (res_valid !== 1'b0 || digit_ready !== 1'b1) begin
                nerr++;
                $display("FAIL frame%0d_ack: rv=%b rdy=%b, want rv=0 rdy=1", f, res_valid, digit_ready);
            end
        end
    endtask

    task automatic test_hold();
        chk_result = 1'b1;
        send_frame(16'h4353);
        @(posedge clk); #1;
        chk_result  = 1'b0;
        digit_in    = 4'h7;
        digit_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            nvec++;
            if (res_valid !== 1'b1 || res_bit !== 1'b1 || err !== 1'b0 ||
                digit_ready !== 1'b0 || num_out !== 16'h4353) begin
                nerr++;
                $display("FAIL hold_c%0d: rv=%b bit=%b err=%b rdy=%b num=%h, want 1 1 0 0 4353",
                         c, res_valid, res_bit, err, digit_ready, num_out);
            end
        end
        handshake_cycle();
        digit_valid = 1'b0;
        nvec++;
        if (res_valid !== 1'b0 || num_out !== 16'h4353 || digit_ready !== 1'b1) begin
            nerr++;
            $display("FAIL hold_release: rv=%b num=%h rdy=%b, want 0 4353 1",
                     res_valid, num_out, digit_ready);
        end
    endtask

    task automatic test_clear();
        int unsigned pulses;
        send_digit(4'h3);
        send_digit(4'h6);
        clear       = 1'b1;
        digit_in    = 4'h5;
        digit_valid = 1'b1;
        @(posedge clk); #1;
        clear       = 1'b0;
        digit_valid = 1'b0;
        nvec++;
        if (num_out !== 16'h0000 || digit_ready !== 1'b1 || res_valid !== 1'b0) begin
            nerr++;
            $display("FAIL clear_state: num=%h rdy=%b rv=%b, want 0000 1 0", num_out, digit_ready, res_valid);
        end
        chk_result = 1'b1;
        send_frame(16'h0363);
        nvec++;
        if (num_out !== 16'h0363) begin
            nerr++;
            $display("FAIL clear_num: got %h want 0363", num_out);
        end
        res_ready = 1'b1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (res_valid === 1'b1) pulses++;
        end
        res_ready = 1'b0;
        nvec++;
        if (pulses != 1) begin
            nerr++;
            $display("FAIL clear_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_async_reset();
        chk_result = 1'b1;
        send_frame(16'h1234);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({res_valid, res_bit, err} !== 3'b000 || num_out !== 16'h0000) begin
            nerr++;
            $display("FAIL async_reset: rv/rb/err=%b%b%b num=%h, want 000 0000",
                     res_valid, res_bit, err, num_out);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        // partial frame then reset: the two early digits must not count
        send_digit(4'h1);
        send_digit(4'h2);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        send_digit(4'h5);
        send_digit(4'h6);
        nvec++;
        if (digit_ready !== 1'b1) begin
            nerr++;
            $display("FAIL midframe_reset: rdy=%b want 1 after 2 post-reset digits", digit_ready);
        end
        send_digit(4'h7);
        send_digit(4'h8);
        nvec++;
        if (digit_ready !== 1'b0 || num_out !== 16'h8765) begin
            nerr++;
            $display("FAIL midframe_frame: rdy=%b num=%h, want 0 8765", digit_ready, num_out);
        end
        @(posedge clk); #1;
        handshake_cycle();
    endtask

`ifdef BCD_CHECK_SEQ_PASSCNT_EN
    task automatic test_pass_cnt();
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int f = 0; f < 4; f++) begin
            chk_result = (f != 1);
            send_frame(16'h2468);
            @(posedge clk); #1;
            handshake_cycle();
        end
        nvec++;
        if (pass_cnt !== 8'd3) begin
            nerr++;
            $display("FAIL pass_cnt: got %0d want 3", pass_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_hold();
        test_clear();
        test_async_reset();
`ifdef BCD_CHECK_SEQ_PASSCNT_EN
        test_pass_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
